// File: rtl/thread_scheduler_pkg.sv
// Shared types and sizing for the 4-thread issue scheduler.
package thread_scheduler_pkg;

   localparam int unsigned NUM_THREADS = 4;
   localparam int unsigned TID_W       = 2;
   localparam int unsigned GAP_W       = 4;

   typedef logic [TID_W-1:0] tid_t;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_IDLE  = 2'd1,
      ST_RUN   = 2'd2,
      ST_DRAIN = 2'd3
   } state_e;

endpackage

// File: rtl/rr_pick4.sv
// Round-robin picker: first set bit of elig searching upward from ptr+1, wrapping.
module rr_pick4
   import thread_scheduler_pkg::*;
(
   input  logic [NUM_THREADS-1:0] elig,
   input  tid_t                   ptr,
   output logic                   found_c,
   output tid_t                   winner_c
);

   tid_t idx;

   always_comb begin
      found_c  = 1'b0;
      winner_c = '0;
      idx      = '0;
      for (int unsigned i = 1; i <= NUM_THREADS; i++) begin
         idx = ptr + TID_W'(i);
         if (!found_c && elig[idx]) begin
            found_c  = 1'b1;
            winner_c = idx;
         end
      end
   end

endmodule

// File: rtl/thread_scheduler.sv
// Barrel-style thread issue scheduler: register-file clear sweep, then
// round-robin issue with a per-thread minimum re-issue gap.
module thread_scheduler
   import thread_scheduler_pkg::*;
#(
   parameter int unsigned MIN_GAP = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   halt_req,
   input  logic [NUM_THREADS-1:0] thread_en,
   input  logic [NUM_THREADS-1:0] thread_wait,
   output logic [TID_W-1:0]       thread,
   output logic                   thread_valid,
   output logic                   rf_rst,
   output logic                   busy,
   output logic                   init_done
);

   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP - 1);
   localparam tid_t             LAST_TID = TID_W'(NUM_THREADS - 1);

   state_e                              state_q, state_d;
   tid_t                                ptr_q, ptr_d;
   logic [NUM_THREADS-1:0][GAP_W-1:0]   gap_q, gap_d;
   tid_t                                thread_d;
   logic                                valid_d, rf_rst_d, busy_d, init_done_d;
   logic [NUM_THREADS-1:0]              elig;
   logic                                gaps_zero;
   logic                                found_c;
   tid_t                                winner_c;

   // Eligibility and drain-complete detection from current gap counters
   always_comb begin
      elig      = '0;
      gaps_zero = 1'b1;
      for (int unsigned i = 0; i < NUM_THREADS; i++) begin
         elig[i] = thread_en[i] & ~thread_wait[i] & (gap_q[i] == '0);
         if (gap_q[i] != '0) begin
            gaps_zero = 1'b0;
         end
      end
   end

   rr_pick4 u_pick (
      .elig     (elig),
      .ptr      (ptr_q),
      .found_c  (found_c),
      .winner_c (winner_c)
   );

   // The thread register doubles as the sweep index while in INIT
   always_comb begin
      state_d     = state_q;
      thread_d    = thread;
      valid_d     = 1'b0;
      rf_rst_d    = 1'b0;
      init_done_d = init_done;
      ptr_d       = ptr_q;
      for (int unsigned i = 0; i < NUM_THREADS; i++) begin
         gap_d[i] = (gap_q[i] != '0) ? gap_q[i] - GAP_W'(1) : '0;
      end

      unique case (state_q)
         ST_INIT: begin
            if (thread == LAST_TID) begin
               state_d     = ST_IDLE;
               init_done_d = 1'b1;
            end else begin
               thread_d = thread + TID_W'(1);
               rf_rst_d = 1'b1;
            end
         end
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (halt_req) begin
               state_d = ST_DRAIN;
            end else if (found_c) begin
               thread_d        = winner_c;
               valid_d         = 1'b1;
               ptr_d           = winner_c;
               gap_d[winner_c] = GAP_LOAD;
            end
         end
         ST_DRAIN: begin
            if (gaps_zero) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_INIT;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_INIT;
         thread       <= '0;
         thread_valid <= 1'b0;
         rf_rst       <= 1'b1;
         busy         <= 1'b1;
         init_done    <= 1'b0;
         ptr_q        <= LAST_TID;
         gap_q        <= '0;
      end else begin
         state_q      <= state_d;
         thread       <= thread_d;
         thread_valid <= valid_d;
         rf_rst       <= rf_rst_d;
         busy         <= busy_d;
         init_done    <= init_done_d;
         ptr_q        <= ptr_d;
         gap_q        <= gap_d;
      end
   end

endmodule

// File: tb/tb_thread_scheduler.sv
// Self-checking bench for thread_scheduler against a cycle-level behavioural model.
module tb_thread_scheduler;

   localparam int GAP = 4;
   localparam int M_INIT = 0, M_IDLE = 1, M_RUN = 2, M_DRAIN = 3;

   logic       clk = 1'b0;
   logic       rst, start, halt_req;
   logic [3:0] thread_en, thread_wait;
   logic [1:0] thread;
   logic       thread_valid, rf_rst, busy, init_done;
   logic [1:0] g1_thread;
   logic       g1_valid, g1_rf_rst, g1_busy, g1_init_done;

   int checks   = 0;
   int failures = 0;

   // Reference model: spec-level state, cycle of last issue per thread
   int         m_mode, m_init_cnt, m_cyc, m_last;
   int         m_issue [4];
   logic [1:0] m_thread;
   logic       m_valid, m_rf_rst, m_busy, m_init_done;

   thread_scheduler #(.MIN_GAP(GAP)) u_dut (
      .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
      .thread_en(thread_en), .thread_wait(thread_wait),
      .thread(thread), .thread_valid(thread_valid), .rf_rst(rf_rst),
      .busy(busy), .init_done(init_done)
   );

   thread_scheduler #(.MIN_GAP(1)) u_dut_g1 (
      .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
      .thread_en(thread_en), .thread_wait(thread_wait),
      .thread(g1_thread), .thread_valid(g1_valid), .rf_rst(g1_rf_rst),
      .busy(g1_busy), .init_done(g1_init_done)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "timeout");
   end

   task automatic model_reset();
      m_mode = M_INIT; m_init_cnt = 0; m_cyc = 0; m_last = 3;
      for (int t = 0; t < 4; t++) m_issue[t] = -100;
      m_thread = 2'd0; m_valid = 1'b0; m_rf_rst = 1'b1; m_busy = 1'b1; m_init_done = 1'b0;
   endtask

   task automatic model_edge();
      bit pending;
      int t;
      m_valid = 1'b0;
      case (m_mode)
         M_INIT: begin
            m_init_cnt++;
            if (m_init_cnt == 4) begin
               m_mode = M_IDLE; m_rf_rst = 1'b0; m_init_done = 1'b1;
            end else begin
               m_thread = 2'(m_init_cnt);
            end
         end
         M_IDLE: if (start) m_mode = M_RUN;
         M_RUN: begin
            if (halt_req) m_mode = M_DRAIN;
            else begin
               for (int k = 1; k <= 4; k++) begin
                  t = (m_last + k) % 4;
                  if (!m_valid && thread_en[t] && !thread_wait[t] && (m_cyc - m_issue[t] >= GAP)) begin
                     m_valid = 1'b1; m_thread = 2'(t); m_last = t; m_issue[t] = m_cyc;
                  end
               end
            end
         end
         default: begin
            pending = 1'b0;
            for (int k = 0; k < 4; k++) if (m_cyc - m_issue[k] < GAP) pending = 1'b1;
            if (!pending) m_mode = M_IDLE;
         end
      endcase
      m_busy = (m_mode != M_IDLE);
      m_cyc++;
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) model_edge();
      #1;
   endtask

   task automatic reset_and_init();
      start = 1'b0; halt_req = 1'b0; thread_wait = 4'h0;
      rst = 1'b0;
      #1;
      model_reset();
      tick(); tick();
      rst = 1'b1;
      repeat (4) tick();
   endtask

   task automatic start_run();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b0; halt_req = 1'b0; thread_en = 4'h0; thread_wait = 4'h0;
      model_reset();
      tick(); tick();
      checks++;
      if ({thread, thread_valid, rf_rst, busy, init_done} !== 6'b00_0110) begin
         failures++;
         $display("FAIL reset_hold got %b exp %b", {thread, thread_valid, rf_rst, busy, init_done}, 6'b00_0110);
      end
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if ({thread, thread_valid, rf_rst, busy, init_done} !== {2'(k), 4'b0110}) begin
            failures++;
            $display("FAIL init_sweep k=%0d got %b exp %b", k,
                     {thread, thread_valid, rf_rst, busy, init_done}, {2'(k), 4'b0110});
         end
         tick();
      end
      checks++;
      if ({thread, thread_valid, rf_rst, busy, init_done} !== 6'b11_0001) begin
         failures++;
         $display("FAIL init_done got %b exp %b", {thread, thread_valid, rf_rst, busy, init_done}, 6'b11_0001);
      end
   endtask

   task automatic test_all_enabled();
      reset_and_init();
      thread_en = 4'hF;
      start_run();
      for (int k = 0; k < 12; k++) begin
         tick();
         checks++;
         if (thread_valid !== 1'b1 || thread !== 2'(k % 4)) begin
            failures++;
            $display("FAIL all_enabled k=%0d got v=%b thr=%0d exp v=1 thr=%0d", k, thread_valid, thread, k % 4);
         end
      end
   endtask

   task automatic test_single_thread();
      reset_and_init();
      thread_en = 4'b0100;
      start_run();
      for (int k = 0; k < 12; k++) begin
         tick();
         checks++;
         if (thread_valid !== 1'((k % 4) == 0) || thread !== 2'd2) begin
            failures++;
            $display("FAIL single_thread k=%0d got v=%b thr=%0d exp v=%b thr=2", k, thread_valid, thread, (k % 4) == 0);
         end
      end
   endtask

   task automatic test_wait_skip();
      int exp_seq [7] = '{0, 2, 3, 0, 2, 3, 1};
      int got [$];
      reset_and_init();
      thread_en = 4'hF;
      start_run();
      thread_wait = 4'b0010;
      for (int k = 0; k < 10; k++) begin
         if (k == 6) thread_wait = 4'h0;
         tick();
         checks++;
         if ({thread, thread_valid} !== {m_thread, m_valid}) begin
            failures++;
            $display("FAIL wait_model k=%0d got thr=%0d v=%b exp thr=%0d v=%b", k, thread, thread_valid, m_thread, m_valid);
         end
         if (thread_valid === 1'b1) got.push_back(int'(thread));
      end
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (i >= got.size()) begin
            failures++;
            $display("FAIL wait_seq i=%0d got none exp %0d", i, exp_seq[i]);
         end else if (got[i] != exp_seq[i]) begin
            failures++;
            $display("FAIL wait_seq i=%0d got %0d exp %0d", i, got[i], exp_seq[i]);
         end
      end
   endtask

   task automatic test_halt();
      int n;
      reset_and_init();
      thread_en = 4'hF;
      start_run();
      repeat (5) tick();
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      start = 1'b1;
      checks++;
      if (thread_valid !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL halt_stop got v=%b busy=%b exp v=0 busy=1", thread_valid, busy);
      end
      n = 1;
      while (busy === 1'b1 && n < 20) begin
         tick();
         checks++;
         if ({thread_valid, busy} !== {1'b0, m_busy}) begin
            failures++;
            $display("FAIL drain_model n=%0d got v=%b busy=%b exp v=0 busy=%b", n, thread_valid, busy, m_busy);
         end
         if (busy === 1'b1) n++;
      end
      start = 1'b0;
      checks++;
      if (busy !== 1'b0 || n > GAP - 1) begin
         failures++;
         $display("FAIL drain_len got busy=%b cycles=%0d exp busy=0 cycles<=%0d", busy, n, GAP - 1);
      end
   endtask

   task automatic test_reset_mid_run();
      reset_and_init();
      thread_en = 4'hF;
      start_run();
      repeat (3) tick();
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      checks++;
      if ({thread, thread_valid, rf_rst, busy, init_done} !== 6'b00_0110) begin
         failures++;
         $display("FAIL midrun_reset got %b exp %b", {thread, thread_valid, rf_rst, busy, init_done}, 6'b00_0110);
      end
      tick();
      checks++;
      if ({thread, thread_valid, rf_rst} !== 4'b0001) begin
         failures++;
         $display("FAIL midrun_hold got %b exp %b", {thread, thread_valid, rf_rst}, 4'b0001);
      end
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if ({thread, thread_valid, rf_rst} !== {2'(k), 2'b01}) begin
            failures++;
            $display("FAIL midrun_sweep k=%0d got %b exp %b", k, {thread, thread_valid, rf_rst}, {2'(k), 2'b01});
         end
         tick();
      end
      checks++;
      if ({rf_rst, busy, init_done} !== 3'b001) begin
         failures++;
         $display("FAIL midrun_idle got %b exp 001", {rf_rst, busy, init_done});
      end
   endtask

   task automatic test_min_gap_one();
      reset_and_init();
      thread_en = 4'b0100;
      start_run();
      for (int k = 0; k < 8; k++) begin
         tick();
         checks++;
         if (g1_valid !== 1'b1 || g1_thread !== 2'd2) begin
            failures++;
            $display("FAIL min_gap_one k=%0d got v=%b thr=%0d exp v=1 thr=2", k, g1_valid, g1_thread);
         end
      end
   endtask

   task automatic test_random();
      reset_and_init();
      for (int k = 0; k < 600; k++) begin
         thread_en   = 4'($urandom);
         thread_wait = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
         start       = ($urandom_range(0, 7) == 0);
         halt_req    = ($urandom_range(0, 19) == 0);
         tick();
         checks++;
         if ({thread, thread_valid, rf_rst, busy, init_done} !== {m_thread, m_valid, m_rf_rst, m_busy, m_init_done}) begin
            failures++;
            $display("FAIL random k=%0d got thr=%0d v=%b rf=%b busy=%b id=%b exp thr=%0d v=%b rf=%b busy=%b id=%b",
                     k, thread, thread_valid, rf_rst, busy, init_done,
                     m_thread, m_valid, m_rf_rst, m_busy, m_init_done);
         end
      end
      start = 1'b0; halt_req = 1'b0;
   endtask

   initial begin
      test_reset();
      test_all_enabled();
      test_single_thread();
      test_wait_skip();
      test_halt();
      test_reset_mid_run();
      test_min_gap_one();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
